// File: rtl/acc_controller.sv
// ============================================================================
// acc_controller
// ----------------------------------------------------------------------------
// Control FSM for the 16-bit accumulator CPU. Sequences fetch, decode and
// execute, driving every register load, datapath mux and ALU select, plus the
// memory write strobe and the handshake with the iterative multiplier.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   start       level; leaves IDLE and begins fetching
//   opcode      current IR[7:0]
//   zflag       ACC == 0, sampled in DEC
//   mult_done   multiplier result valid
//   muxPC       0 = PC+1, 1 = branch target
//   muxMAR      0 = PC, 1 = IR[15:8]
//   muxACC      00 ALU, 01 MDR, 10 multiplier, 11 zero
//   loadMAR/loadPC/loadACC/loadMDR/loadIR   register load enables
//   opALU       00 ADD, 01 SUB, 10 AND, 11 OR
//   mem_we      write MemD to M[MemAddr] this cycle
//   mult_load   start a multiply
//   mult_reset  hold the multiplier in reset
//   halted      HALT has executed
//   err         sticky: illegal opcode or multiply timeout
// ============================================================================
module acc_controller #(
    parameter int MUL_TIMEOUT = 32,
    parameter int TCW         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] opcode,
    input  logic       zflag,
    input  logic       mult_done,
    output logic       muxPC,
    output logic       muxMAR,
    output logic [1:0] muxACC,
    output logic       loadMAR,
    output logic       loadPC,
    output logic       loadACC,
    output logic       loadMDR,
    output logic       loadIR,
    output logic [1:0] opALU,
    output logic       mem_we,
    output logic       mult_load,
    output logic       mult_reset,
    output logic       halted,
    output logic       err
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_F1       = 4'd1;
    localparam logic [3:0] ST_F2       = 4'd2;
    localparam logic [3:0] ST_F3       = 4'd3;
    localparam logic [3:0] ST_DEC      = 4'd4;
    localparam logic [3:0] ST_RD       = 4'd5;
    localparam logic [3:0] ST_EX       = 4'd6;
    localparam logic [3:0] ST_WR       = 4'd7;
    localparam logic [3:0] ST_MUL_LOAD = 4'd8;
    localparam logic [3:0] ST_MUL_WAIT = 4'd9;
    localparam logic [3:0] ST_MUL_WB   = 4'd10;
    localparam logic [3:0] ST_HLT      = 4'd11;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_AND   = 8'h05;
    localparam logic [7:0] OP_OR    = 8'h06;
    localparam logic [7:0] OP_MUL   = 8'h07;
    localparam logic [7:0] OP_JMP   = 8'h08;
    localparam logic [7:0] OP_JZ    = 8'h09;
    localparam logic [7:0] OP_CLR   = 8'h0A;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [TCW-1:0] MUL_LAST = TCW'(MUL_TIMEOUT - 1);

    logic [3:0]     state;
    logic [3:0]     next_state;
    logic [TCW-1:0] mul_cnt;
    logic           set_err;
    logic           mul_timeout;

    assign mul_timeout = (mul_cnt == MUL_LAST);

    // Next-state and output decode. Outputs come from the state register; the
    // DEC/RD/EX states also look at opcode, which is held steady by IR, so the
    // strobes never glitch within a state. The multiplier is kept in reset in
    // every state except while a multiply is being launched or awaited.
    always_comb begin
        next_state = state;
        muxPC      = 1'b0;
        muxMAR     = 1'b0;
        muxACC     = 2'b00;
        loadMAR    = 1'b0;
        loadPC     = 1'b0;
        loadACC    = 1'b0;
        loadMDR    = 1'b0;
        loadIR     = 1'b0;
        opALU      = 2'b00;
        mem_we     = 1'b0;
        mult_load  = 1'b0;
        mult_reset = 1'b1;
        halted     = 1'b0;
        set_err    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_F1;
            end
            ST_F1: begin
                loadMAR    = 1'b1;
                next_state = ST_F2;
            end
            ST_F2: begin
                loadMDR    = 1'b1;
                loadPC     = 1'b1;
                next_state = ST_F3;
            end
            ST_F3: begin
                loadIR     = 1'b1;
                next_state = ST_DEC;
            end
            ST_DEC: begin
                next_state = ST_F1;
                case (opcode)
                    OP_NOP: ;
                    OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: begin
                        loadMAR    = 1'b1;
                        muxMAR     = 1'b1;
                        next_state = ST_RD;
                    end
                    OP_STORE: begin
                        loadMAR    = 1'b1;
                        muxMAR     = 1'b1;
                        next_state = ST_WR;
                    end
                    OP_JMP: begin
                        loadPC = 1'b1;
                        muxPC  = 1'b1;
                    end
                    OP_JZ: begin
                        loadPC = zflag;
                        muxPC  = zflag;
                    end
                    OP_CLR: begin
                        loadACC = 1'b1;
                        muxACC  = 2'b11;
                    end
                    OP_HALT: next_state = ST_HLT;
                    default: set_err = 1'b1;
                endcase
            end
            ST_RD: begin
                loadMDR    = 1'b1;
                next_state = (opcode == OP_MUL) ? ST_MUL_LOAD : ST_EX;
            end
            ST_EX: begin
                loadACC    = 1'b1;
                next_state = ST_F1;
                case (opcode)
                    OP_LOAD: muxACC = 2'b01;
                    OP_SUB:  opALU  = 2'b01;
                    OP_AND:  opALU  = 2'b10;
                    OP_OR:   opALU  = 2'b11;
                    default: opALU  = 2'b00;
                endcase
            end
            ST_WR: begin
                mem_we     = 1'b1;
                next_state = ST_F1;
            end
            ST_MUL_LOAD: begin
                mult_load  = 1'b1;
                mult_reset = 1'b0;
                next_state = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                mult_reset = 1'b0;
                // A result arriving on the final allowed cycle still counts.
                if (mult_done) begin
                    next_state = ST_MUL_WB;
                end else if (mul_timeout) begin
                    set_err    = 1'b1;
                    next_state = ST_F1;
                end
            end
            ST_MUL_WB: begin
                loadACC    = 1'b1;
                muxACC     = 2'b10;
                next_state = ST_F1;
            end
            ST_HLT: begin
                halted = 1'b1;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register, multiply watchdog counter and sticky error flag. The
    // counter restarts on every multiply launch so each MUL gets a full budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            mul_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_MUL_LOAD) begin
                mul_cnt <= '0;
            end else if (state == ST_MUL_WAIT) begin
                mul_cnt <= mul_cnt + TCW'(1);
            end
            if (set_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_acc_controller.sv
// ============================================================================
// tb_acc_controller
// ----------------------------------------------------------------------------
// Directed, table-driven bench for acc_controller. Each table row holds the
// inputs for one clock cycle and the full output word expected in that cycle.
// Multi-cycle corners (multiply timeout, illegal opcode, HALT, asynchronous
// reset mid-instruction) are hand-built sequences on the same machinery.
// ============================================================================
module tb_acc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] opcode;
    logic       zflag;
    logic       mult_done;
    logic       muxPC, muxMAR;
    logic [1:0] muxACC;
    logic       loadMAR, loadPC, loadACC, loadMDR, loadIR;
    logic [1:0] opALU;
    logic       mem_we, mult_load, mult_reset, halted, err;

    int nChecks = 0;
    int nFails  = 0;

    // Output word: {muxPC, muxMAR, muxACC[1:0], loadMAR, loadPC, loadACC,
    //               loadMDR, loadIR, opALU[1:0], mem_we, mult_load,
    //               mult_reset, halted, err}
    localparam logic [15:0] MUXPC    = 16'h8000;
    localparam logic [15:0] MUXMAR   = 16'h4000;
    localparam logic [15:0] ACC_MDR  = 16'h1000;
    localparam logic [15:0] ACC_MUL  = 16'h2000;
    localparam logic [15:0] ACC_ZERO = 16'h3000;
    localparam logic [15:0] LMAR     = 16'h0800;
    localparam logic [15:0] LPC      = 16'h0400;
    localparam logic [15:0] LACC     = 16'h0200;
    localparam logic [15:0] LMDR     = 16'h0100;
    localparam logic [15:0] LIR      = 16'h0080;
    localparam logic [15:0] ALU_SUB  = 16'h0020;
    localparam logic [15:0] ALU_AND  = 16'h0040;
    localparam logic [15:0] ALU_OR   = 16'h0060;
    localparam logic [15:0] WE       = 16'h0010;
    localparam logic [15:0] ML       = 16'h0008;
    localparam logic [15:0] MR       = 16'h0004;
    localparam logic [15:0] HALT     = 16'h0002;
    localparam logic [15:0] ERR      = 16'h0001;

    typedef struct {
        logic        start;
        logic [7:0]  op;
        logic        z;
        logic        md;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    logic [15:0] actual;
    assign actual = {muxPC, muxMAR, muxACC, loadMAR, loadPC, loadACC,
                     loadMDR, loadIR, opALU, mem_we, mult_load,
                     mult_reset, halted, err};

    acc_controller #(.MUL_TIMEOUT(32), .TCW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .zflag      (zflag),
        .mult_done  (mult_done),
        .muxPC      (muxPC),
        .muxMAR     (muxMAR),
        .muxACC     (muxACC),
        .loadMAR    (loadMAR),
        .loadPC     (loadPC),
        .loadACC    (loadACC),
        .loadMDR    (loadMDR),
        .loadIR     (loadIR),
        .opALU      (opALU),
        .mem_we     (mem_we),
        .mult_load  (mult_load),
        .mult_reset (mult_reset),
        .halted     (halted),
        .err        (err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] exp);
        nChecks++;
        if (actual !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, exp);
        end
    endtask

    // Drive one row's inputs on the falling edge; they steer the next rising edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        start     = v.start;
        opcode    = v.op;
        zflag     = v.z;
        mult_done = v.md;
        #1;
    endtask

    task automatic addRow(input logic s, input logic [7:0] op, input logic z,
                          input logic md, input logic [15:0] exp, input string name);
        vec_t v;
        v.start = s; v.op = op; v.z = z; v.md = md; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic addFetch(input logic [7:0] op, input logic z, input logic [15:0] e);
        addRow(1'b0, op, z, 1'b0, LMAR | MR | e, "f1");
        addRow(1'b0, op, z, 1'b0, LMDR | LPC | MR | e, "f2");
        addRow(1'b0, op, z, 1'b0, LIR | MR | e, "f3");
    endtask

    task automatic runQueue();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].exp);
        end
        vecs.delete();
    endtask

    task automatic doReset();
        rst = 1'b1; start = 1'b0; opcode = 8'h00; zflag = 1'b0; mult_done = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset", MR);
        rst = 1'b0;
    endtask

    // Pulse reset between clock edges and check outputs before any edge arrives.
    task automatic asyncResetCheck(input string name);
        #1 rst = 1'b1;
        #1 checkOutput(name, MR);
    endtask

    initial begin
        rst = 1'b1;
        doReset();

        // ---------------- main instruction table ----------------
        addRow(1'b0, 8'h0A, 1'b0, 1'b0, MR, "idle_hold");
        addRow(1'b1, 8'h0A, 1'b0, 1'b0, MR, "idle_go");
        // CLR
        addFetch(8'h0A, 1'b0, '0);
        addRow(1'b0, 8'h0A, 1'b0, 1'b0, LACC | ACC_ZERO | MR, "clr_dec");
        // LOAD
        addFetch(8'h01, 1'b0, '0);
        addRow(1'b0, 8'h01, 1'b0, 1'b0, LMAR | MUXMAR | MR, "load_dec");
        addRow(1'b0, 8'h01, 1'b0, 1'b0, LMDR | MR, "load_rd");
        addRow(1'b0, 8'h01, 1'b0, 1'b0, LACC | ACC_MDR | MR, "load_ex");
        // ADD / SUB / AND / OR
        addFetch(8'h03, 1'b0, '0);
        addRow(1'b0, 8'h03, 1'b0, 1'b0, LMAR | MUXMAR | MR, "add_dec");
        addRow(1'b0, 8'h03, 1'b0, 1'b0, LMDR | MR, "add_rd");
        addRow(1'b0, 8'h03, 1'b0, 1'b0, LACC | MR, "add_ex");
        addFetch(8'h04, 1'b0, '0);
        addRow(1'b0, 8'h04, 1'b0, 1'b0, LMAR | MUXMAR | MR, "sub_dec");
        addRow(1'b0, 8'h04, 1'b0, 1'b0, LMDR | MR, "sub_rd");
        addRow(1'b0, 8'h04, 1'b0, 1'b0, LACC | ALU_SUB | MR, "sub_ex");
        addFetch(8'h05, 1'b0, '0);
        addRow(1'b0, 8'h05, 1'b0, 1'b0, LMAR | MUXMAR | MR, "and_dec");
        addRow(1'b0, 8'h05, 1'b0, 1'b0, LMDR | MR, "and_rd");
        addRow(1'b0, 8'h05, 1'b0, 1'b0, LACC | ALU_AND | MR, "and_ex");
        addFetch(8'h06, 1'b0, '0);
        addRow(1'b0, 8'h06, 1'b0, 1'b0, LMAR | MUXMAR | MR, "or_dec");
        addRow(1'b0, 8'h06, 1'b0, 1'b0, LMDR | MR, "or_rd");
        addRow(1'b0, 8'h06, 1'b0, 1'b0, LACC | ALU_OR | MR, "or_ex");
        // STORE: one write cycle, then straight back to fetch
        addFetch(8'h02, 1'b0, '0);
        addRow(1'b0, 8'h02, 1'b0, 1'b0, LMAR | MUXMAR | MR, "st_dec");
        addRow(1'b0, 8'h02, 1'b0, 1'b0, WE | MR, "st_wr");
        // JZ taken / not taken, JMP, NOP
        addFetch(8'h09, 1'b1, '0);
        addRow(1'b0, 8'h09, 1'b1, 1'b0, LPC | MUXPC | MR, "jz_taken");
        addFetch(8'h09, 1'b0, '0);
        addRow(1'b0, 8'h09, 1'b0, 1'b0, MR, "jz_not");
        addFetch(8'h08, 1'b0, '0);
        addRow(1'b0, 8'h08, 1'b0, 1'b0, LPC | MUXPC | MR, "jmp_dec");
        addFetch(8'h00, 1'b0, '0);
        addRow(1'b0, 8'h00, 1'b0, 1'b0, MR, "nop_dec");
        // MUL with mult_done nine cycles after mult_load
        addFetch(8'h07, 1'b0, '0);
        addRow(1'b0, 8'h07, 1'b0, 1'b0, LMAR | MUXMAR | MR, "mul_dec");
        addRow(1'b0, 8'h07, 1'b0, 1'b0, LMDR | MR, "mul_rd");
        addRow(1'b0, 8'h07, 1'b0, 1'b0, ML, "mul_load");
        for (int i = 0; i < 8; i++) addRow(1'b0, 8'h07, 1'b0, 1'b0, '0, "mul_wait");
        addRow(1'b0, 8'h07, 1'b0, 1'b1, '0, "mul_done");
        addRow(1'b0, 8'h07, 1'b0, 1'b0, LACC | ACC_MUL | MR, "mul_wb");
        addFetch(8'h00, 1'b0, '0);
        runQueue();

        // ---------------- mult_done on the last allowed cycle ----------------
        doReset();
        addRow(1'b1, 8'h07, 1'b0, 1'b0, MR, "idle_go");
        addFetch(8'h07, 1'b0, '0);
        addRow(1'b0, 8'h07, 1'b0, 1'b0, LMAR | MUXMAR | MR, "mulb_dec");
        addRow(1'b0, 8'h07, 1'b0, 1'b0, LMDR | MR, "mulb_rd");
        addRow(1'b0, 8'h07, 1'b0, 1'b0, ML, "mulb_load");
        for (int i = 0; i < 31; i++) addRow(1'b0, 8'h07, 1'b0, 1'b0, '0, "mulb_wait");
        addRow(1'b0, 8'h07, 1'b0, 1'b1, '0, "mulb_last");
        addRow(1'b0, 8'h07, 1'b0, 1'b0, LACC | ACC_MUL | MR, "mulb_wb");
        addRow(1'b0, 8'h00, 1'b0, 1'b0, LMAR | MR, "mulb_f1");
        runQueue();

        // ---------------- multiply timeout, then reset mid-F2 ----------------
        doReset();
        addRow(1'b1, 8'h07, 1'b0, 1'b0, MR, "idle_go");
        addFetch(8'h07, 1'b0, '0);
        addRow(1'b0, 8'h07, 1'b0, 1'b0, LMAR | MUXMAR | MR, "mult_dec");
        addRow(1'b0, 8'h07, 1'b0, 1'b0, LMDR | MR, "mult_rd");
        addRow(1'b0, 8'h07, 1'b0, 1'b0, ML, "mult_load");
        for (int i = 0; i < 32; i++) addRow(1'b0, 8'h07, 1'b0, 1'b0, '0, "mult_wait");
        addRow(1'b0, 8'h00, 1'b0, 1'b0, LMAR | MR | ERR, "mult_f1");
        addRow(1'b0, 8'h00, 1'b0, 1'b0, LMDR | LPC | MR | ERR, "mult_f2");
        runQueue();
        asyncResetCheck("async_rst_f2");

        // ---------------- illegal opcode acts as NOP and sets err ----------------
        doReset();
        addRow(1'b1, 8'h77, 1'b0, 1'b0, MR, "idle_go");
        addFetch(8'h77, 1'b0, '0);
        addRow(1'b0, 8'h77, 1'b0, 1'b0, MR, "ill_dec");
        addRow(1'b0, 8'h0A, 1'b0, 1'b0, LMAR | MR | ERR, "ill_f1");
        addRow(1'b0, 8'h0A, 1'b0, 1'b0, LMDR | LPC | MR | ERR, "ill_f2");
        addRow(1'b0, 8'h0A, 1'b0, 1'b0, LIR | MR | ERR, "ill_f3");
        addRow(1'b0, 8'h0A, 1'b0, 1'b0, LACC | ACC_ZERO | MR | ERR, "ill_clr");
        runQueue();

        // ---------------- reset during the STORE write cycle ----------------
        doReset();
        addRow(1'b1, 8'h02, 1'b0, 1'b0, MR, "idle_go");
        addFetch(8'h02, 1'b0, '0);
        addRow(1'b0, 8'h02, 1'b0, 1'b0, LMAR | MUXMAR | MR, "st2_dec");
        addRow(1'b0, 8'h02, 1'b0, 1'b0, WE | MR, "st2_wr");
        runQueue();
        asyncResetCheck("async_rst_wr");

        // ---------------- HALT holds for 100 cycles ----------------
        doReset();
        addRow(1'b1, 8'hFF, 1'b0, 1'b0, MR, "idle_go");
        addFetch(8'hFF, 1'b0, '0);
        addRow(1'b0, 8'hFF, 1'b0, 1'b0, MR, "halt_dec");
        for (int i = 0; i < 100; i++)
            addRow(1'b1, (i % 2 == 0) ? 8'h01 : 8'h0A, 1'b1, 1'b1, HALT | MR, "halt_hold");
        runQueue();
        doReset();
        addRow(1'b0, 8'h00, 1'b0, 1'b0, MR, "post_halt_idle");
        runQueue();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
